// File: rtl/term_mac_seq_if.sv
// Term stream and frame result bundle for term_mac_seq.
// The master drives terms and result_ready; the slave (the MAC) returns ready, result and count.
interface term_mac_seq_if #(
  parameter int A_W   = 9,
  parameter int B_W   = 8,
  parameter int OUT_W = 17,
  parameter int CNT_W = 8
);
  logic             term_valid;
  logic             term_ready;
  logic [A_W-1:0]   term_a;
  logic [B_W-1:0]   term_b;
  logic             term_gate;
  logic             term_bypass;
  logic             term_last;
  logic             result_valid;
  logic             result_ready;
  logic [OUT_W-1:0] result;
  logic [CNT_W-1:0] term_count;

  modport master (
    output term_valid, term_a, term_b, term_gate, term_bypass, term_last, result_ready,
    input  term_ready, result_valid, result, term_count
  );

  modport slave (
    input  term_valid, term_a, term_b, term_gate, term_bypass, term_last, result_ready,
    output term_ready, result_valid, result, term_count
  );
endinterface

// File: rtl/term_mac_seq.sv
// Time-multiplexed gated sum-of-products engine: one term per transfer, shift-add multiply,
// one result per frame.
module term_mac_seq #(
  parameter int A_W   = 9,
  parameter int B_W   = 8,
  parameter int OUT_W = 17,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  term_mac_seq_if.slave bus
);
  localparam int IT_W = (B_W > 1) ? $clog2(B_W) : 1;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_nxt;
  logic [OUT_W-1:0] a_sh;
  logic [B_W-1:0]   b_sh;
  logic [OUT_W-1:0] partial;
  logic [OUT_W-1:0] partial_nxt;
  logic [IT_W-1:0]  iter;
  logic             last_q;
  logic [OUT_W-1:0] result_q;
  logic             result_valid_q;
  logic [CNT_W-1:0] count_q;

  logic accept;
  logic start_mul;
  logic mul_done;
  logic enter_done;
  logic result_take;

  assign bus.term_ready   = (state == ST_READY);
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.term_count   = count_q;

  assign accept      = bus.term_valid & bus.term_ready;
  assign start_mul   = accept & ~bus.term_bypass & ~bus.term_gate;
  assign mul_done    = (state == ST_MUL) && (iter == '0);
  assign enter_done  = (accept & ~start_mul & bus.term_last) | (mul_done & last_q);
  assign result_take = (state == ST_DONE) & bus.result_ready;

  // The final multiply step must include its own conditional add before folding into acc.
  always_comb begin
    partial_nxt = partial;
    if (b_sh[0]) begin
      partial_nxt = partial + a_sh;
    end
  end

  always_comb begin
    acc_nxt = acc;
    if (accept && bus.term_bypass) begin
      acc_nxt = acc + OUT_W'(bus.term_a);
    end else if (mul_done) begin
      acc_nxt = acc + partial_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_READY;
    end else begin
      case (state)
        ST_READY: begin
          if (accept) begin
            if (start_mul) begin
              state <= ST_MUL;
            end else if (bus.term_last) begin
              state <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (iter == '0) begin
            state <= last_q ? ST_DONE : ST_READY;
          end
        end
        ST_DONE: begin
          if (bus.result_ready) begin
            state <= ST_READY;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Shift-add multiplier: always runs the full B_W iterations, even for zero operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      partial <= '0;
      iter    <= '0;
      last_q  <= 1'b0;
    end else if (start_mul) begin
      a_sh    <= OUT_W'(bus.term_a);
      b_sh    <= bus.term_b;
      partial <= '0;
      iter    <= IT_W'(B_W - 1);
      last_q  <= bus.term_last;
    end else if (state == ST_MUL) begin
      a_sh    <= a_sh << 1;
      b_sh    <= b_sh >> 1;
      partial <= partial_nxt;
      iter    <= iter - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      count_q <= '0;
    end else if (result_take) begin
      acc     <= '0;
      count_q <= '0;
    end else begin
      acc <= acc_nxt;
      if (accept) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // result is captured on the same edge that updates acc, then held until the next frame ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (enter_done) begin
      result_q       <= acc_nxt;
      result_valid_q <= 1'b1;
    end else if (result_take) begin
      result_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_term_mac_seq.sv
// Self-checking bench for term_mac_seq: fixed single-term vectors, hand-written multi-cycle
// sequences, and random frames against an arithmetic reference model.
module tb_term_mac_seq;
  localparam int A_W   = 9;
  localparam int B_W   = 8;
  localparam int OUT_W = 17;
  localparam int CNT_W = 8;
  localparam longint MODV = 64'd1 << OUT_W;
  localparam int TIMEOUT = 60;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  term_mac_seq_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  term_mac_seq #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           gate;
    logic           bypass;
    int             exp_result;
    int             exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents one term at a falling edge once ready is high; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                               input logic gate, input logic bypass, input logic last,
                               output int stall);
    stall = 0;
    while (!bus.term_ready && stall < TIMEOUT) begin
      @(negedge clk);
      stall++;
    end
    if (!bus.term_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    bus.term_valid  = 1'b1;
    bus.term_a      = a;
    bus.term_b      = b;
    bus.term_gate   = gate;
    bus.term_bypass = bypass;
    bus.term_last   = last;
    @(negedge clk);
    bus.term_valid  = 1'b0;
    bus.term_last   = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!bus.result_valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.result_valid) checkOutput("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic takeResult();
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
  endtask

  function automatic longint termValue(input int a, input int b, input bit gate, input bit bypass);
    if (bypass) return longint'(a);
    if (gate) return 0;
    return longint'(a) * longint'(b);
  endfunction

  initial begin
    int     stall;
    int     lat;
    longint exp_sum;
    int     n_terms;

    vecs[0] = '{a: 9'd3,   b: 8'd5,   gate: 1'b0, bypass: 1'b0, exp_result: 15,     exp_lat: B_W};
    vecs[1] = '{a: 9'd0,   b: 8'd0,   gate: 1'b0, bypass: 1'b0, exp_result: 0,      exp_lat: B_W};
    vecs[2] = '{a: 9'd511, b: 8'd255, gate: 1'b0, bypass: 1'b0, exp_result: 130305, exp_lat: B_W};
    vecs[3] = '{a: 9'd511, b: 8'd255, gate: 1'b1, bypass: 1'b0, exp_result: 0,      exp_lat: 0};
    vecs[4] = '{a: 9'd7,   b: 8'd255, gate: 1'b0, bypass: 1'b1, exp_result: 7,      exp_lat: 0};
    vecs[5] = '{a: 9'd300, b: 8'd9,   gate: 1'b1, bypass: 1'b1, exp_result: 300,    exp_lat: 0};
    vecs[6] = '{a: 9'd1,   b: 8'd1,   gate: 1'b0, bypass: 1'b0, exp_result: 1,      exp_lat: B_W};
    vecs[7] = '{a: 9'd2,   b: 8'd128, gate: 1'b0, bypass: 1'b0, exp_result: 256,    exp_lat: B_W};
    vecs[8] = '{a: 9'd257, b: 8'd3,   gate: 1'b0, bypass: 1'b0, exp_result: 771,    exp_lat: B_W};

    bus.term_valid   = 1'b0;
    bus.term_a       = '0;
    bus.term_b       = '0;
    bus.term_gate    = 1'b0;
    bus.term_bypass  = 1'b0;
    bus.term_last    = 1'b0;
    bus.result_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_result_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("reset_result", 32'(bus.result), 32'd0);
    checkOutput("reset_term_count", 32'(bus.term_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_term_ready", 32'(bus.term_ready), 32'd1);

    $display("[TB] single-term vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].gate, vecs[i].bypass, 1'b1, stall);
      waitResult(lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d_result", i), 32'(bus.result), 32'(vecs[i].exp_result));
      checkOutput($sformatf("vec%0d_count", i), 32'(bus.term_count), 32'd1);
      checkOutput($sformatf("vec%0d_ready_in_done", i), 32'(bus.term_ready), 32'd0);
      takeResult();
    end

    $display("[TB] gated term then bypass term, back-to-back");
    applyStimulus(9'd511, 8'd255, 1'b1, 1'b0, 1'b0, stall);
    checkOutput("b2b_ready_after_gate", 32'(bus.term_ready), 32'd1);
    applyStimulus(9'd7, 8'd0, 1'b0, 1'b1, 1'b1, stall);
    checkOutput("b2b_no_stall", 32'(stall), 32'd0);
    waitResult(lat);
    checkOutput("b2b_latency", 32'(lat), 32'd0);
    checkOutput("b2b_result", 32'(bus.result), 32'd7);
    checkOutput("b2b_count", 32'(bus.term_count), 32'd2);
    takeResult();

    $display("[TB] accumulator wrap");
    applyStimulus(9'd511, 8'd255, 1'b0, 1'b0, 1'b0, stall);
    applyStimulus(9'd511, 8'd255, 1'b0, 1'b0, 1'b1, stall);
    checkOutput("wrap_mul_stall", 32'(stall), 32'(B_W));
    waitResult(lat);
    checkOutput("wrap_result", 32'(bus.result), 32'd129538);
    checkOutput("wrap_count", 32'(bus.term_count), 32'd2);

    $display("[TB] backpressure in result hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_result", 32'(bus.result), 32'd129538);
      checkOutput("hold_valid", 32'(bus.result_valid), 32'd1);
      checkOutput("hold_count", 32'(bus.term_count), 32'd2);
      checkOutput("hold_ready", 32'(bus.term_ready), 32'd0);
    end
    takeResult();
    checkOutput("post_take_ready", 32'(bus.term_ready), 32'd1);
    checkOutput("post_take_valid", 32'(bus.result_valid), 32'd0);
    applyStimulus(9'd2, 8'd2, 1'b0, 1'b0, 1'b1, stall);
    waitResult(lat);
    checkOutput("after_bp_result", 32'(bus.result), 32'd4);
    checkOutput("after_bp_count", 32'(bus.term_count), 32'd1);
    takeResult();

    $display("[TB] reset during multiply");
    applyStimulus(9'd100, 8'd200, 1'b0, 1'b0, 1'b1, stall);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("midrst_result", 32'(bus.result), 32'd0);
    checkOutput("midrst_count", 32'(bus.term_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(bus.term_ready), 32'd1);
    applyStimulus(9'd1, 8'd1, 1'b0, 1'b0, 1'b1, stall);
    waitResult(lat);
    checkOutput("midrst_next_result", 32'(bus.result), 32'd1);
    checkOutput("midrst_next_count", 32'(bus.term_count), 32'd1);
    takeResult();

    $display("[TB] random frames");
    for (int f = 0; f < 30; f++) begin
      exp_sum = 0;
      n_terms = $urandom_range(1, 5);
      for (int t = 0; t < n_terms; t++) begin
        int a;
        int b;
        bit g;
        bit byp;
        a   = $urandom_range(0, (1 << A_W) - 1);
        b   = $urandom_range(0, (1 << B_W) - 1);
        g   = 1'($urandom_range(0, 1));
        byp = ($urandom_range(0, 3) == 0);
        exp_sum = (exp_sum + termValue(a, b, g, byp)) % MODV;
        applyStimulus(A_W'(a), B_W'(b), g, byp, (t == n_terms - 1), stall);
      end
      waitResult(lat);
      checkOutput($sformatf("rand%0d_result", f), 32'(bus.result), 32'(exp_sum));
      checkOutput($sformatf("rand%0d_count", f), 32'(bus.term_count), 32'(n_terms));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      takeResult();
    end

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
